// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Data has priority, but a burst counter lets a waiting fetch through after MAX_DATA_BURST data grants.
module mem_arbiter #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_DATA_BURST);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic          we;
  logic          owner;
  logic          grant_d;
  assign grant_d   = d_req & (~if_req | (burst_cnt != MAXB));
  assign mem_read  = (state == ACCESS) & ~we;
  assign mem_write = (state == ACCESS) & we;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      we        <= 1'b0;
      owner     <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: if (if_req | d_req) begin
          state     <= ACCESS;
          owner     <= grant_d;
          we        <= grant_d & d_we;
          mem_addr  <= grant_d ? d_addr : if_addr;
          mem_wdata <= grant_d ? d_wdata : mem_wdata;
          // only data grants that leave a fetch waiting count toward the burst
          burst_cnt <= (grant_d & if_req) ? ((burst_cnt == MAXB) ? MAXB : burst_cnt + BW'(1)) : '0;
        end
        ACCESS: begin
          state  <= DONE;
          rdata  <= we ? rdata : mem_rdata;
          if_ack <= ~owner;
          d_ack  <= owner;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected acks checked by an independent monitor.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [4:0]  if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        if_ack, d_ack, mem_read, mem_write, busy;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [4:0]  mem_addr;
  logic [31:0] mem [32];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural memory: combinational read, write at the rising edge
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  typedef struct packed {logic dat; logic [31:0] val;} exp_t;
  exp_t        q[$];
  exp_t        e;
  int          total = 0, bad = 0;
  logic [31:0] last_rd = '0;
  int          n, wc, acks;
  logic        acc_rd, acc_busy;
  logic [4:0]  acc_addr;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  task automatic push(input logic dat, input logic rd, input logic [31:0] v);
    if (rd) last_rd = v;
    q.push_back({dat, last_rd});
  endtask

  task automatic wait_ack(input logic dat, input int lim);
    n = 0;
    wc = 0;
    do begin
      @(negedge clk);
      n++;
      wc += int'(mem_write);
      if (n == 1) begin
        acc_rd = mem_read;
        acc_addr = mem_addr;
        acc_busy = busy;
      end
    end while (!(dat ? d_ack : if_ack) && n < lim);
  endtask

  task automatic issue(input logic dat, input logic we, input logic [4:0] a, input logic [31:0] wd);
    @(negedge clk);
    if (dat) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    wait_ack(dat, 20);
    if (dat) d_req = 1'b0; else if_req = 1'b0;
  endtask

  always @(negedge clk) if (rst_n && (if_ack || d_ack)) begin
    chk("ack_excl", 32'(if_ack & d_ack), 32'd0);
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_ack: got if_ack=%b d_ack=%b want none", if_ack, d_ack);
    end else begin
      e = q.pop_front();
      chk("ack_owner", 32'(d_ack), 32'(e.dat));
      chk("ack_rdata", rdata, e.val);
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[3] = 32'h8C010004;
    mem[9] = 32'h1;
    mem[2] = 32'h22222222;
    #1;
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // 1: fetch addr 3
    push(1'b0, 1'b1, 32'h8C010004);
    issue(1'b0, 1'b0, 5'd3, '0);
    chk("t1_acc_read", 32'(acc_rd), 32'd1);
    chk("t1_acc_addr", 32'(acc_addr), 32'd3);
    chk("t1_acc_busy", 32'(acc_busy), 32'd1);
    chk("t1_latency", n, 2);
    // 2: write then read back addr 7
    push(1'b1, 1'b0, '0);
    issue(1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
    chk("t2_wr_cycles", wc, 1);
    chk("t2_wr_latency", n, 2);
    push(1'b1, 1'b1, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 5'd7, '0);
    chk("t2_rd_latency", n, 2);
    // 3: both held: D,D,D,F,D,D,D,F,D
    for (int i = 0; i < 9; i++)
      if (i == 3 || i == 7) push(1'b0, 1'b1, 32'h8C010004);
      else push(1'b1, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    if_req = 1'b1; if_addr = 5'd3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 5'd7;
    acks = 0;
    n = 0;
    while (acks < 9 && n < 100) begin
      @(negedge clk);
      n++;
      if (if_ack || d_ack) acks++;
    end
    if_req = 1'b0;
    d_req = 1'b0;
    chk("t3_acks", acks, 9);
    chk("t3_burst_after", 32'(dut.burst_cnt), 32'd1);
    // 4: lone write clears the burst, then fetch
    push(1'b1, 1'b0, '0);
    issue(1'b1, 1'b1, 5'd12, 32'h12345678);
    chk("t4_burst", 32'(dut.burst_cnt), 32'd0);
    push(1'b0, 1'b1, 32'h8C010004);
    issue(1'b0, 1'b0, 5'd3, '0);
    chk("t4_fetch_latency", n, 2);
    chk("t4_mem12", mem[12], 32'h12345678);
    // 6: d_req held across ack with new fields
    push(1'b1, 1'b0, '0);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 5'd12; d_wdata = 32'hA5A5A5A5;
    wait_ack(1'b1, 20);
    chk("t6_first_latency", n, 2);
    d_we = 1'b0; d_addr = 5'd2;
    push(1'b1, 1'b1, 32'h22222222);
    wait_ack(1'b1, 20);
    d_req = 1'b0;
    chk("t6_second_latency", n, 3);
    chk("t6_mem12", mem[12], 32'hA5A5A5A5);
    // 5: reset during ACCESS of a write to addr 9
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 5'd9; d_wdata = 32'h0000FFFF;
    @(negedge clk);
    chk("t5_acc_write", 32'(mem_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_mem_write", 32'(mem_write), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_rdata", rdata, 32'd0);
    chk("t5_d_ack", 32'(d_ack), 32'd0);
    d_req = 1'b0;
    last_rd = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_mem9", mem[9], 32'h1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
